// File: rtl/totient_pkg.sv
// Shared definitions for the Euler-totient display path.
//   IDX_W      : width of the index n, the GCD operand k and the coprime count
//   state_e    : sequencer states, in the order a full index update visits them
//   hex_to_seg : maps a display value to segments {A,B,C,D,E,F,G}, 1 = lit
package totient_pkg;

  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    ST_DWELL,
    ST_ADVANCE,
    ST_INIT,
    ST_GCD_GO,
    ST_GCD_WAIT,
    ST_ACCUM,
    ST_LATCH
  } state_e;

  // Only 0..F can be shown. Any wider value blanks the digit rather than
  // aliasing onto a wrong digit.
  function automatic logic [6:0] hex_to_seg(input logic [IDX_W-1:0] val);
    logic [6:0] seg;
    seg = 7'b0000000;
    case (val)
      5'h00: seg = 7'b1111110;
      5'h01: seg = 7'b0110000;
      5'h02: seg = 7'b1101101;
      5'h03: seg = 7'b1111001;
      5'h04: seg = 7'b0110011;
      5'h05: seg = 7'b1011011;
      5'h06: seg = 7'b1011111;
      5'h07: seg = 7'b1110000;
      5'h08: seg = 7'b1111111;
      5'h09: seg = 7'b1111011;
      5'h0A: seg = 7'b1110111;
      5'h0B: seg = 7'b0011111;
      5'h0C: seg = 7'b1001110;
      5'h0D: seg = 7'b0111101;
      5'h0E: seg = 7'b1001111;
      5'h0F: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/gcd_sub_unit.sv
// Subtractive GCD engine.
//   clk_0, R : clock and synchronous active-high reset
//   start    : loads a and b. It is ignored while a reduction is running.
//   a, b     : operands. Both must be >= 1.
//   done     : one-cycle pulse when the operands have converged
//   result   : the GCD. It stays valid after done until the next result.
module gcd_sub_unit
  import totient_pkg::*;
(
  input  logic             clk_0,
  input  logic             R,
  input  logic             start,
  input  logic [IDX_W-1:0] a,
  input  logic [IDX_W-1:0] b,
  output logic             done,
  output logic [IDX_W-1:0] result
);

  logic [IDX_W-1:0] opA_q, opA_d, opB_q, opB_d, result_q, result_d;
  logic             run_q, run_d, done_q, done_d;

  // Each running cycle replaces the larger operand with the difference.
  // Equal operands mean the GCD has been reached.
  always_comb begin
    opA_d    = opA_q;
    opB_d    = opB_q;
    run_d    = run_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (!run_q) begin
      if (start) begin
        opA_d = a;
        opB_d = b;
        run_d = 1'b1;
      end
    end else if (opA_q == opB_q) begin
      done_d   = 1'b1;
      result_d = opA_q;
      run_d    = 1'b0;
    end else if (opA_q > opB_q) begin
      opA_d = opA_q - opB_q;
    end else begin
      opB_d = opB_q - opA_q;
    end
  end

  // Register stage. Reset abandons any reduction in flight.
  always_ff @(posedge clk_0) begin
    if (R) begin
      opA_q    <= '0;
      opB_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      run_q    <= run_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/totient_seq_ctrl.sv
// Sequencer for the Euler-totient seven-segment display.
//   clk_0, R      : clock and synchronous active-high reset
//   dir           : 0 steps the index up and 1 steps it down. Both wrap.
//                   It is sampled when the index advances.
//   hold          : freezes the dwell timer and blocks step
//   step          : ends the dwell early
//   A..G          : segment drives for phi(n), 1 = lit
//   n_out         : current index
//   busy          : high while phi(n) is being computed
//   valid         : one-cycle pulse when the displayed value updates
module totient_seq_ctrl
  import totient_pkg::*;
#(
  parameter int N_MAX     = 16,
  parameter int DWELL_CYC = 4
) (
  input  logic             clk_0,
  input  logic             R,
  input  logic             dir,
  input  logic             hold,
  input  logic             step,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             E,
  output logic             F,
  output logic             G,
  output logic [IDX_W-1:0] n_out,
  output logic             busy,
  output logic             valid
);

  localparam logic [IDX_W-1:0] N_LAST     = IDX_W'(N_MAX);
  localparam logic [IDX_W-1:0] ONE        = IDX_W'(1);
  localparam logic [15:0]      DWELL_LAST = 16'(DWELL_CYC - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d, k_q, k_d, cnt_q, cnt_d, disp_q, disp_d;
  logic [15:0]      dwell_q, dwell_d;
  logic             valid_q, valid_d;

  logic             gcdStart, gcdDone;
  logic [IDX_W-1:0] gcdResult;

  gcd_sub_unit u_gcd (
    .clk_0  (clk_0),
    .R      (R),
    .start  (gcdStart),
    .a      (n_q),
    .b      (k_q),
    .done   (gcdDone),
    .result (gcdResult)
  );

  // State register.
  always_ff @(posedge clk_0) begin
    if (R) state_q <= ST_DWELL;
    else   state_q <= state_d;
  end

  // Next-state logic. In DWELL, hold takes priority, so a step that
  // arrives while hold is high has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DWELL:    if (!hold && (step || dwell_q == DWELL_LAST)) state_d = ST_ADVANCE;
      ST_ADVANCE:  state_d = ST_INIT;
      ST_INIT:     state_d = ST_GCD_GO;
      ST_GCD_GO:   state_d = ST_GCD_WAIT;
      ST_GCD_WAIT: if (gcdDone) state_d = ST_ACCUM;
      ST_ACCUM:    state_d = (k_q == n_q) ? ST_LATCH : ST_GCD_GO;
      ST_LATCH:    state_d = ST_DWELL;
      default:     state_d = ST_DWELL;
    endcase
  end

  // Datapath next values. The coprime count builds in cnt_q. disp_q changes
  // only at LATCH, so the previous phi stays on the display until then.
  always_comb begin
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    dwell_d = dwell_q;
    valid_d = 1'b0;
    case (state_q)
      ST_DWELL:   if (!hold) dwell_d = dwell_q + 16'd1;
      ST_ADVANCE: begin
        if (!dir) n_d = (n_q == N_LAST) ? ONE : n_q + ONE;
        else      n_d = (n_q == ONE) ? N_LAST : n_q - ONE;
      end
      ST_INIT: begin
        k_d   = ONE;
        cnt_d = '0;
      end
      ST_ACCUM: begin
        if (gcdResult == ONE) cnt_d = cnt_q + ONE;
        if (k_q != n_q)       k_d   = k_q + ONE;
      end
      ST_LATCH: begin
        disp_d  = cnt_q;
        valid_d = 1'b1;
        dwell_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers. Reset shows phi(1) = 1 at index 1.
  always_ff @(posedge clk_0) begin
    if (R) begin
      n_q     <= ONE;
      k_q     <= ONE;
      cnt_q   <= '0;
      disp_q  <= ONE;
      dwell_q <= '0;
      valid_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
    end
  end

  // Outputs. The segments decode the registered display value, so they change
  // on the same edge that raises valid.
  always_comb begin
    gcdStart            = (state_q == ST_GCD_GO);
    busy                = (state_q inside {ST_INIT, ST_GCD_GO, ST_GCD_WAIT, ST_ACCUM});
    {A, B, C, D, E, F, G} = hex_to_seg(disp_q);
    n_out               = n_q;
    valid               = valid_q;
  end

endmodule

// File: tb/tb_totient_seq_ctrl.sv
// Directed bench for totient_seq_ctrl. It runs an up sweep with wrap, a down
// sweep from reset, a hold/step check and a reset abort.
module tb_totient_seq_ctrl;
  import totient_pkg::*;

  logic             clk_0 = 1'b0;
  logic             R, dir, hold, step;
  logic             A, B, C, D, E, F, G;
  logic [IDX_W-1:0] n_out;
  logic             busy, valid;
  logic [6:0]       seg;

  int vecCount  = 0;
  int missCount = 0;
  bit prevValid = 1'b0;

  typedef struct {
    bit         doReset;
    bit         dirIn;
    int         nExp;
    logic [6:0] segExp;
  } vec_t;

  vec_t vecs[20];

  totient_seq_ctrl #(.N_MAX(16), .DWELL_CYC(4)) dut (
    .clk_0 (clk_0),
    .R     (R),
    .dir   (dir),
    .hold  (hold),
    .step  (step),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G),
    .n_out (n_out),
    .busy  (busy),
    .valid (valid)
  );

  always #5 clk_0 = ~clk_0;

  assign seg = {A, B, C, D, E, F, G};

  // valid must be exactly one cycle wide. busy must be low in the DWELL
  // cycle that carries valid.
  always @(negedge clk_0) begin
    if (valid) begin
      vecCount++;
      if (prevValid || busy) begin
        missCount++;
        $display("[TB] FAIL valid_pulse: prevValid=%0b busy=%0b, required prevValid=0 busy=0", prevValid, busy);
      end
    end
    prevValid = valid;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitValid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_0);
      if (valid) found = 1'b1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bit found;
    if (v.doReset) begin
      R = 1'b1;
      repeat (3) @(negedge clk_0);
      R = 1'b0;
    end
    dir = v.dirIn;
    waitValid(found);
    checkOutput($sformatf("valid_seen_n%0d", v.nExp), found, 1);
    checkOutput($sformatf("n_out_n%0d", v.nExp), n_out, v.nExp);
    checkOutput($sformatf("seg_n%0d", v.nExp), seg, v.segExp);
  endtask

  initial begin
    bit found;
    bit sawValid;

    // Up sweep through the wrap, then a down sweep from reset.
    vecs[0]  = '{0, 0,  2, 7'b0110000};
    vecs[1]  = '{0, 0,  3, 7'b1101101};
    vecs[2]  = '{0, 0,  4, 7'b1101101};
    vecs[3]  = '{0, 0,  5, 7'b0110011};
    vecs[4]  = '{0, 0,  6, 7'b1101101};
    vecs[5]  = '{0, 0,  7, 7'b1011111};
    vecs[6]  = '{0, 0,  8, 7'b0110011};
    vecs[7]  = '{0, 0,  9, 7'b1011111};
    vecs[8]  = '{0, 0, 10, 7'b0110011};
    vecs[9]  = '{0, 0, 11, 7'b1110111};
    vecs[10] = '{0, 0, 12, 7'b0110011};
    vecs[11] = '{0, 0, 13, 7'b1001110};
    vecs[12] = '{0, 0, 14, 7'b1011111};
    vecs[13] = '{0, 0, 15, 7'b1111111};
    vecs[14] = '{0, 0, 16, 7'b1111111};
    vecs[15] = '{0, 0,  1, 7'b0110000};
    vecs[16] = '{0, 0,  2, 7'b0110000};
    vecs[17] = '{1, 1, 16, 7'b1111111};
    vecs[18] = '{0, 1, 15, 7'b1111111};
    vecs[19] = '{0, 1, 14, 7'b1011111};

    R = 1'b1; dir = 1'b0; hold = 1'b0; step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_0);
      checkOutput("reset_seg", seg, 7'b0110000);
      checkOutput("reset_n_out", n_out, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_valid", valid, 0);
    end
    R = 1'b0;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);

    // While hold is high there is no advance, and a step is dropped.
    hold = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_0);
      if (valid) sawValid = 1'b1;
    end
    checkOutput("hold_no_valid", sawValid, 0);
    checkOutput("hold_n_stable", n_out, 14);
    checkOutput("hold_busy_low", busy, 0);
    step = 1'b1;
    @(negedge clk_0);
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_0);
      if (valid) sawValid = 1'b1;
    end
    checkOutput("hold_step_no_valid", sawValid, 0);
    checkOutput("hold_step_n_stable", n_out, 14);

    // After hold is released, one step advances immediately, which the
    // 4-cycle dwell would not.
    hold = 1'b0; step = 1'b1; dir = 1'b1;
    @(negedge clk_0);
    step = 1'b0;
    checkOutput("step_advance_pending", n_out, 14);
    @(negedge clk_0);
    checkOutput("step_advanced", n_out, 13);
    waitValid(found);
    checkOutput("step_valid_seen", found, 1);
    checkOutput("step_seg_n13", seg, 7'b1001110);

    // Go up to 14, then back down to 13, and abort that computation.
    dir = 1'b0;
    waitValid(found);
    checkOutput("abort_pre_valid", found, 1);
    checkOutput("abort_pre_n", n_out, 14);
    dir = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_0);
      if (busy && n_out == 13) found = 1'b1;
    end
    checkOutput("abort_busy_on_13", found, 1);
    repeat (20) @(negedge clk_0);
    checkOutput("abort_still_busy", busy, 1);
    R = 1'b1;
    @(negedge clk_0);
    R = 1'b0;
    checkOutput("abort_n_out", n_out, 1);
    checkOutput("abort_seg", seg, 7'b0110000);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", valid, 0);
    waitValid(found);
    checkOutput("post_abort_valid_seen", found, 1);
    checkOutput("post_abort_n", n_out, 16);
    checkOutput("post_abort_seg", seg, 7'b1111111);

    repeat (2) @(negedge clk_0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/totient_seq_ctrl.md
Name: totient_seq_ctrl

Overview:
- Sequencer and controller for the Euler-totient seven-segment display path.
- Steps an index n through 1..N_MAX, up or down with wrap-around, and dwells on each value for a programmable number of clk_0 cycles.
- For each index it computes phi(n) by counting k in 1..n with gcd(n,k)==1, running a subtractive-GCD sub-unit under a start/done handshake.
- Latches each result into the display register and drives segments A..G.

Parameters:
- N_MAX, 16: last index. Legal range 2..16, so phi fits in one hex digit.
- DWELL_CYC, 4: cycles the display is held before advancing. Minimum 1.
- IDX_W, 5: index, k and count width.

Ports:
- clk_0  in  1  system clock; all state updates on rising edge.
- R  in  1  synchronous active-high reset.
- dir  in  1  0 = count up, 1 = count down. Sampled only at the advance point.
- hold  in  1  freezes the dwell counter while high.
- step  in  1  single-cycle request to end the dwell early.
- A,B,C,D,E,F,G  out  1 each  segment drive, active-high (1 = lit).
- n_out  out  IDX_W  index currently displayed.
- busy  out  1  high while a computation is in progress.
- valid  out  1  one-cycle pulse when the display register updates.

Behaviour:
- Reset (R=1 at an edge), taking priority over everything:
  - n=1, disp=1, segments = 0110000, valid=0, busy=0.
  - State DWELL, dwell counter = 0.
  - GCD sub-unit returns to idle.
  - Reset mid-computation aborts it; no valid pulse is produced.
- States: DWELL -> ADVANCE -> INIT -> GCD_GO -> GCD_WAIT -> ACCUM -> (GCD_GO or LATCH) -> DWELL.
- DWELL:
  - The counter increments each cycle when hold=0.
  - Exit to ADVANCE when counter==DWELL_CYC-1 with hold=0, or when step=1 with hold=0.
  - hold=1 overrides step; a step that arrives during hold is dropped.
- ADVANCE:
  - dir=0: n = (n==N_MAX) ? 1 : n+1.
  - dir=1: n = (n==1) ? N_MAX : n-1.
  - n_out tracks n from this cycle on.
- INIT: k=1, cnt=0, busy=1.
- GCD_GO: start=1 for one cycle with a=n, b=k.
- GCD_WAIT: wait for the sub-unit's done pulse.
- ACCUM:
  - If result==1 then cnt++.
  - If k==n, go to LATCH; otherwise k++ and go to GCD_GO.
- LATCH:
  - disp=cnt, valid=1 for one cycle, busy=0, dwell counter cleared, go to DWELL.
- The display shows the previous phi until LATCH. hold has no effect on a computation already in progress.
- Widths: k, n and cnt are IDX_W bits unsigned. cnt never exceeds 15 for N_MAX≤16. gcd(1,1)=1, so phi(1)=1.
- Segment encoding is hex 0..F in ABCDEFG order:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Segments are registered from disp: they change the cycle after LATCH, coincident with valid.

Decomposition:
- totient_pkg holds:
  - the state enum;
  - IDX_W;
  - the seg7 constant table / hex_to_seg function.
- Sub-module gcd_sub_unit:
  - Inputs: clk_0, R, start, a, b (IDX_W each). Outputs: done (1-cycle pulse), result.
  - Operands are loaded on start; each cycle the larger operand is replaced by larger-smaller.
  - done fires when the operands are equal; result = that value.
  - Both inputs are ≥1, so the loop terminates in ≤ max(a,b) cycles.
  - start while busy is ignored.

Test Plan:
- Reset for 3 cycles, then release, dir=0, DWELL_CYC=4 -> segments 0110000 and n_out=1 during and after reset. Successive valid pulses then show n=2..16 with phi = 1,2,2,4,2,6,4,6,4,A,4,C,6,8,8 (e.g. n=11 -> 1110111, n=13 -> 1001110, n=16 -> 1111111).
- Continue past n=16 with dir=0 -> wraps to n=1 with phi 1 (0110000), then n=2 -> 1.
- From reset, dir=1 -> first advance is to n=16, display 8 (1111111), then n=15 -> 8 and n=14 -> 6 (1011111).
- Assert hold for 50 cycles while in DWELL -> no valid pulse and n_out unchanged. Then step together with hold -> ignored. Release hold, pulse step once -> ADVANCE on the next cycle and valid within the bounded latency.
- Assert R while busy=1 on n=13 -> next cycle n_out=1, segments 0110000, busy=0, and no valid pulse from the aborted run.
- Across all runs, valid is exactly one cycle wide, busy is low in DWELL, and each computation finishes within 400 cycles (bench timeout).
